// File: rtl/rf_rename.sv
// Architectural register file with per-register ROB rename nicks; nick 0 means the value is ready.
// Define RF_BYPASS_EN to forward a same-cycle commit to the dispatch reads.
module rf_rename #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NICK_W  = 5,
  parameter int unsigned NAME_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iROB_en,
  input  logic [NAME_W-1:0] iROB_rd_regnm,
  input  logic [DATA_W-1:0] iROB_rd_dt,
  input  logic [NICK_W-1:0] iROB_rd_nick,
  input  logic [NAME_W-1:0] iID_rs1_regnm,
  input  logic [NAME_W-1:0] iID_rs2_regnm,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [NICK_W-1:0] oDP_rs2_nick
);

  logic [DATA_W-1:0] dt_q   [REG_NUM];
  logic [NICK_W-1:0] nick_q [REG_NUM];

  logic commit_en;
  logic rename_en;

  assign commit_en = iROB_en && rdy && (iROB_rd_regnm != '0);
  assign rename_en = iROB_nick_en && rdy && !clr && (iROB_nick_regnm != '0);

  // Later assignments win: a same-cycle rename overrides the commit tag-clear, clr overrides both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        dt_q[i]   <= '0;
        nick_q[i] <= '0;
      end
    end else if (rdy) begin
      if (commit_en) begin
        dt_q[iROB_rd_regnm] <= iROB_rd_dt;
        if (nick_q[iROB_rd_regnm] == iROB_rd_nick) begin
          nick_q[iROB_rd_regnm] <= '0;
        end
      end
      if (clr) begin
        for (int i = 0; i < REG_NUM; i++) begin
          nick_q[i] <= '0;
        end
      end else if (rename_en) begin
        nick_q[iROB_nick_regnm] <= iROB_nick;
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic byp_en;
  assign byp_en = iROB_en && (iROB_rd_regnm != '0);
`endif

  // Source 1 read; x0 is hardwired to ready zero.
  always_comb begin
    oDP_rs1_dt   = '0;
    oDP_rs1_nick = '0;
    if (iID_rs1_regnm != '0) begin
      oDP_rs1_dt   = dt_q[iID_rs1_regnm];
      oDP_rs1_nick = nick_q[iID_rs1_regnm];
`ifdef RF_BYPASS_EN
      if (byp_en && (iID_rs1_regnm == iROB_rd_regnm) &&
          (nick_q[iID_rs1_regnm] == iROB_rd_nick)) begin
        oDP_rs1_dt   = iROB_rd_dt;
        oDP_rs1_nick = '0;
      end
`endif
    end
  end

  // Source 2 read, same rules as source 1.
  always_comb begin
    oDP_rs2_dt   = '0;
    oDP_rs2_nick = '0;
    if (iID_rs2_regnm != '0) begin
      oDP_rs2_dt   = dt_q[iID_rs2_regnm];
      oDP_rs2_nick = nick_q[iID_rs2_regnm];
`ifdef RF_BYPASS_EN
      if (byp_en && (iID_rs2_regnm == iROB_rd_regnm) &&
          (nick_q[iID_rs2_regnm] == iROB_rd_nick)) begin
        oDP_rs2_dt   = iROB_rd_dt;
        oDP_rs2_nick = '0;
      end
`endif
    end
  end

endmodule
